// File: rtl/truth_table_scanner.sv
// Stimulus/response scanner: drives every input code onto a combinational block and
// packs the sampled output into a truth-table word. Optional compare logic: TT_SCAN_CHECK_EN.
module truth_table_scanner #(
  parameter int N_IN          = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   f,
  output logic [N_IN-1:0]        abcd,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   table_out
`ifdef TT_SCAN_CHECK_EN
  ,
  input  logic [(1<<N_IN)-1:0]   expected,
  output logic                   mismatch,
  output logic [N_IN:0]          err_count
`endif
);

  localparam int TABLE_W = 1 << N_IN;
  localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  // One extra index bit keeps the terminal compare from aliasing with code 0.
  localparam logic [N_IN:0] LAST_INDEX  = {1'b0, {N_IN{1'b1}}};
  localparam logic [N_IN:0] INDEX_ONE   = {{N_IN{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t             state, state_next;
  logic [N_IN:0]      index, index_next;
  logic [7:0]         settle_cnt, settle_next;
  logic [TABLE_W-1:0] table_next;
`ifdef TT_SCAN_CHECK_EN
  logic [N_IN:0]      err_next;
  logic               mismatch_next;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      index      <= '0;
      settle_cnt <= '0;
      table_out  <= '0;
`ifdef TT_SCAN_CHECK_EN
      err_count  <= '0;
      mismatch   <= 1'b0;
`endif
    end else begin
      index      <= index_next;
      settle_cnt <= settle_next;
      table_out  <= table_next;
`ifdef TT_SCAN_CHECK_EN
      err_count  <= err_next;
      mismatch   <= mismatch_next;
`endif
    end
  end

  // NOTE: every signal driven here gets a hold-value default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_next    = state;
    index_next    = index;
    settle_next   = settle_cnt;
    table_next    = table_out;
`ifdef TT_SCAN_CHECK_EN
    err_next      = err_count;
    mismatch_next = mismatch;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next    = SCAN;
          index_next    = '0;
          settle_next   = '0;
          table_next    = '0;
`ifdef TT_SCAN_CHECK_EN
          err_next      = '0;
          mismatch_next = 1'b0;
`endif
        end
      end
      SCAN: begin
        if (settle_cnt == SETTLE_LAST) begin
          settle_next                   = '0;
          table_next[index[N_IN-1:0]]   = f;
`ifdef TT_SCAN_CHECK_EN
          if (f != expected[index[N_IN-1:0]]) err_next = err_count + INDEX_ONE;
`endif
          if (index == LAST_INDEX) begin
            state_next = DONE;
`ifdef TT_SCAN_CHECK_EN
            // Uses the post-sample count so the final code's compare is included.
            mismatch_next = (err_next != '0);
`endif
          end else begin
            index_next = index + INDEX_ONE;
          end
        end else begin
          settle_next = settle_cnt + 8'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
        index_next = '0;
      end
      default: state_next = IDLE;
    endcase
  end

  assign abcd = index[N_IN-1:0];
  assign busy = (state == SCAN);
  assign done = (state == DONE);

endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Sequential stimulus/response engine for 4-input single-output combinational blocks. On `start` it drives every input code 0..2^N_IN-1 onto the block under test, waits a settle interval, and samples the block's output. It assembles the samples into a packed truth-table word, so logic blocks are characterised in hardware rather than by a file-driven bench. It sits beside the block under test: `abcd` feeds the block's input vector and `f` takes its output.

## Interface
- `N_IN`, 4: width of the driven input vector; the table width is 2^N_IN.
- `SETTLE_CYCLES`, 2: cycles each code is held before `f` is sampled; legal range 1..255.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start` input 1: request a scan; honoured only in IDLE.
- `f` input 1: output of the block under test.
- `abcd` output N_IN: input code driven to the block under test.
- `busy` output 1: high while a scan is in progress.
- `done` output 1: one-cycle pulse after the last sample.
- `table_out` output 2^N_IN: bit i holds `f` sampled while `abcd` == i.
- `expected` input 2^N_IN (TT_SCAN_CHECK_EN only): reference truth table.
- `mismatch` output 1 (TT_SCAN_CHECK_EN only): any bit differs.
- `err_count` output N_IN+1 (TT_SCAN_CHECK_EN only): number of differing bits.

## Operation
- Reset (`rst_n`=0 at an edge) puts the FSM in IDLE and forces `abcd`=0, `busy`=0, `done`=0, `table_out`=0, `mismatch`=0 and `err_count`=0.
- States:
  - IDLE: `start`=1 moves to SCAN, clears `table_out`, index=0, settle counter=0, and clears the check outputs.
  - SCAN: `abcd`=index. The settle counter increments each cycle. When the counter reaches SETTLE_CYCLES-1, the FSM writes `f` into `table_out[index]` and resets the counter. If index = 2^N_IN-1 it moves to DONE; otherwise index increments.
  - DONE: `done`=1 for exactly one cycle, then the FSM returns to IDLE.
- `busy`=1 in SCAN only.
- `abcd` returns to 0 on entry to IDLE.
- `table_out` holds its value from DONE until the next accepted `start` or reset.
- `start` asserted in SCAN or DONE is ignored; it is not queued.
- A level-held `start` in IDLE restarts the scan immediately after DONE.
- Index width is N_IN+1 internally so the terminal compare cannot wrap to 0 early.
- Reset mid-scan aborts the scan with no `done` pulse. All outputs take their reset values at that edge.

## Timing
- Let the `start` sampling edge be E0. `busy`=1 and `abcd`=0 are visible after E0.
- Code i is driven during cycles E0+1+i·S … E0+(i+1)·S, where S = SETTLE_CYCLES.
- `f` is sampled at edge E0+(i+1)·S.
- `done` is high during the cycle following edge E0+2^N_IN·S. With defaults that is E0+32.
- `busy` falls at the same edge `done` rises.
- `table_out[i]` is valid from the edge after its sample. The full word is valid while `done`=1.
- Consecutive scans are separated by at least one IDLE cycle after DONE.
- `f` must be stable within S-1 cycles of an `abcd` change. For a combinational block under test, S=1 is sufficient.

## Configuration
- `TT_SCAN_CHECK_EN` defined:
  - `expected`, `mismatch` and `err_count` ports exist.
  - At each sample, `err_count` increments if `f` != `expected[index]`.
  - `mismatch` is registered as (`err_count` != 0) and updates in the same cycle `done` is high.
  - Both are cleared on an accepted `start` and on reset.
- `TT_SCAN_CHECK_EN` undefined: those ports and all compare logic are absent. Scan behaviour and timing are identical.

## Test plan
- Reset and idle: hold `rst_n`=0 for 2 edges, then release with `start`=0 for 5 cycles -> `abcd`=0, `busy`=0, `done`=0, `table_out`=0 throughout.
- Full scan, defaults: block under test has F=0 at codes 1, 9, 11 and 13, F=1 otherwise; pulse `start` -> `busy` for 32 cycles, `abcd` steps 0..15 every 2 cycles, `done` pulses once at E0+32, `table_out`=16'hD5FD.
- Settle and ignored start: SETTLE_CYCLES=1, `f` tied to `abcd[0]`, `start` re-pulsed at E0+5 -> `done` at E0+16 only, no second scan, `table_out`=16'hAAAA.
- Reset mid-scan: pull `rst_n` low at E0+10 -> no `done`; `busy`=0, `abcd`=0 and `table_out`=0 after that edge. A new `start` then completes normally with 16'hD5FD.
- Check feature (macro defined), same block as the full-scan case:
  - `expected`=16'hD5FD -> `mismatch`=0, `err_count`=0.
  - `expected`=16'hFFFF -> `mismatch`=1, `err_count`=4.
- Back-to-back: hold `start`=1 continuously -> `done` pulses at E0+32 and again at E0+66, each followed by one IDLE cycle.
